// File: rtl/pipe_pkg.sv
// Shared defaults and channel record for the MEM->WB write-back pipeline.
package pipe_pkg;

    localparam int XLEN_DEFAULT   = 64;
    localparam int REG_AW_DEFAULT = 5;

    typedef struct packed {
        logic [REG_AW_DEFAULT-1:0] addr;
        logic [XLEN_DEFAULT-1:0]   data;
        logic                      wen;
    } wb_ch_t;

endpackage

// File: rtl/wb_sanitize.sv
// Capture-side write-enable masking: drops x0 writes and older writes that a
// younger channel in the same bundle overwrites.
module wb_sanitize
    import pipe_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [NUM_CH*REG_AW-1:0] addr,
    input  logic [NUM_CH-1:0]        wen,
    output logic [NUM_CH-1:0]        wen_clean
);

    // Per-channel mask; a higher channel index is younger and wins the conflict.
    always_comb begin
        wen_clean = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            wen_clean[c] = wen[c] && (addr[c*REG_AW +: REG_AW] != {REG_AW{1'b0}});
            for (int k = c + 1; k < NUM_CH; k++) begin
                if (wen[k] && (addr[k*REG_AW +: REG_AW] == addr[c*REG_AW +: REG_AW])) begin
                    wen_clean[c] = 1'b0;
                end else begin
                    wen_clean[c] = wen_clean[c];
                end
            end
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and capture-side write-enable sanitisation.
module mem_wb_pipe
    import pipe_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NUM_CH*REG_AW-1:0] rd_addr_i,
    input  logic [NUM_CH*XLEN-1:0]   rd_data_i,
    input  logic [NUM_CH-1:0]        rd_wen_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NUM_CH*REG_AW-1:0] rd_addr_o,
    output logic [NUM_CH*XLEN-1:0]   rd_data_o,
    output logic [NUM_CH-1:0]        rd_wen_o,
    output logic [1:0]               occ_o
);

    logic                     main_valid_r, skid_valid_r;
    logic [NUM_CH*REG_AW-1:0] main_addr_r, skid_addr_r;
    logic [NUM_CH*XLEN-1:0]   main_data_r, skid_data_r;
    logic [NUM_CH-1:0]        main_wen_r, skid_wen_r;

    logic                     accept_s, deliver_s;
    logic                     main_valid_nxt_s, skid_valid_nxt_s;
    logic                     main_from_skid_s, main_from_in_s, skid_from_in_s;
    logic [NUM_CH-1:0]        wen_clean_s;

    wb_sanitize #(
        .NUM_CH (NUM_CH),
        .REG_AW (REG_AW)
    ) u_sanitize (
        .addr      (rd_addr_i),
        .wen       (rd_wen_i),
        .wen_clean (wen_clean_s)
    );

    // Entry routing; flush outranks every accept, deliver and refill.
    always_comb begin
        accept_s         = in_valid_i && !skid_valid_r;
        deliver_s        = main_valid_r && out_ready_i;
        main_valid_nxt_s = main_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        main_from_skid_s = 1'b0;
        main_from_in_s   = 1'b0;
        skid_from_in_s   = 1'b0;
        if (flush_i) begin
            main_valid_nxt_s = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (skid_valid_r && deliver_s) begin
            main_from_skid_s = 1'b1;
            skid_valid_nxt_s = 1'b0;
        end else if (!main_valid_r || deliver_s) begin
            main_valid_nxt_s = accept_s;
            main_from_in_s   = accept_s;
        end else if (accept_s) begin
            skid_from_in_s   = 1'b1;
            skid_valid_nxt_s = 1'b1;
        end else begin
            skid_valid_nxt_s = skid_valid_r;
        end
    end

    // Valid flags for the two entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            main_valid_r <= main_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
        end
    end

    // MAIN payload; held while invalid so the outputs keep the last bundle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_addr_r <= {(NUM_CH*REG_AW){1'b0}};
            main_data_r <= {(NUM_CH*XLEN){1'b0}};
            main_wen_r  <= {NUM_CH{1'b0}};
        end else if (main_from_skid_s) begin
            main_addr_r <= skid_addr_r;
            main_data_r <= skid_data_r;
            main_wen_r  <= skid_wen_r;
        end else if (main_from_in_s) begin
            main_addr_r <= rd_addr_i;
            main_data_r <= rd_data_i;
            main_wen_r  <= wen_clean_s;
        end else begin
            main_addr_r <= main_addr_r;
        end
    end

    // SKID payload, only written when MAIN is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_addr_r <= {(NUM_CH*REG_AW){1'b0}};
            skid_data_r <= {(NUM_CH*XLEN){1'b0}};
            skid_wen_r  <= {NUM_CH{1'b0}};
        end else if (skid_from_in_s) begin
            skid_addr_r <= rd_addr_i;
            skid_data_r <= rd_data_i;
            skid_wen_r  <= wen_clean_s;
        end else begin
            skid_addr_r <= skid_addr_r;
        end
    end

    assign in_ready_o  = !skid_valid_r;
    assign out_valid_o = main_valid_r;
    assign rd_addr_o   = main_addr_r;
    assign rd_data_o   = main_data_r;
    assign rd_wen_o    = main_wen_r & {NUM_CH{main_valid_r}};
    assign occ_o       = {1'b0, main_valid_r} + {1'b0, skid_valid_r};

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe (NUM_CH=2/XLEN=64 plus a NUM_CH=1/XLEN=32 build).
`timescale 1ns/1ps
module tb_mem_wb_pipe;
    import pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, flush, in_valid, out_ready;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_wen;
    logic         in_ready, out_valid;
    logic [9:0]   addr_o;
    logic [127:0] data_o;
    logic [1:0]   wen_o;
    logic [1:0]   occ;

    logic         u_flush, u_in_valid, u_in_ready, u_out_valid, u_out_ready;
    logic [4:0]   u_addr, u_addr_o;
    logic [31:0]  u_data, u_data_o;
    logic         u_wen, u_wen_o;
    logic [1:0]   u_occ;

    mem_wb_pipe #(.NUM_CH(2), .XLEN(64), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .rd_addr_i(rd_addr), .rd_data_i(rd_data), .rd_wen_i(rd_wen),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .rd_addr_o(addr_o), .rd_data_o(data_o), .rd_wen_o(wen_o), .occ_o(occ)
    );

    mem_wb_pipe #(.NUM_CH(1), .XLEN(32), .REG_AW(5)) dut1 (
        .clk(clk), .rst(rst), .flush_i(u_flush), .in_valid_i(u_in_valid), .in_ready_o(u_in_ready),
        .rd_addr_i(u_addr), .rd_data_i(u_data), .rd_wen_i(u_wen),
        .out_valid_o(u_out_valid), .out_ready_i(u_out_ready),
        .rd_addr_o(u_addr_o), .rd_data_o(u_data_o), .rd_wen_o(u_wen_o), .occ_o(u_occ)
    );

    typedef wb_ch_t [1:0] bundle_t;
    bundle_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every delivered bundle must match the head of the queue.
    always @(negedge clk) begin
        bundle_t b;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bundle", {118'd0, addr_o}, 128'd0);
            end else begin
                b = exp_q.pop_front();
                chk("out_addr", {118'd0, addr_o}, {118'd0, b[1].addr, b[0].addr});
                chk("out_data", data_o, {b[1].data, b[0].data});
                chk("out_wen", {126'd0, wen_o}, {126'd0, b[1].wen, b[0].wen});
            end
        end
    end

    task automatic cyc(input logic v, input logic [4:0] a1, input logic [4:0] a0,
                       input logic [63:0] d1, input logic [63:0] d0,
                       input logic [1:0] w, input logic [1:0] ew, input logic fl);
        bundle_t b;
        in_valid = v;
        rd_addr  = {a1, a0};
        rd_data  = {d1, d0};
        rd_wen   = w;
        flush    = fl;
        if (v && in_ready && !fl) begin
            b[0] = '{addr: a0, data: d0, wen: ew[0]};
            b[1] = '{addr: a1, data: d1, wen: ew[1]};
            exp_q.push_back(b);
        end
        @(posedge clk); #1;
        if (fl) exp_q.delete();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [1:0] wi;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rd_addr = 10'd0; rd_data = 128'd0; rd_wen = 2'b00;
        u_flush = 1'b0; u_in_valid = 1'b0; u_out_ready = 1'b1;
        u_addr = 5'd0; u_data = 32'd0; u_wen = 1'b0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_addr", addr_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_wen", wen_o, 0);
        chk("rst_occ", occ, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Narrow build: single 32-bit channel
        u_in_valid = 1'b1; u_addr = 5'd3; u_data = 32'hDEADBEEF; u_wen = 1'b1;
        @(posedge clk); #1;
        u_in_valid = 1'b0;
        chk("n1_valid", u_out_valid, 1);
        chk("n1_data", u_data_o, 32'hDEADBEEF);
        chk("n1_wen", u_wen_o, 1);

        // Sanitisation with latency check while held
        out_ready = 1'b0;
        cyc(1'b1, 5'd5, 5'd5, 64'h1111, 64'h2222, 2'b11, 2'b10, 1'b0);
        chk("lat_valid", out_valid, 1);
        chk("san_conflict", wen_o, 2'b10);
        chk("san_occ1", occ, 1);
        out_ready = 1'b1;
        cyc(1'b1, 5'd0, 5'd0, 64'h3333, 64'h4444, 2'b11, 2'b00, 1'b0);
        cyc(1'b1, 5'd7, 5'd0, 64'h5555, 64'h6666, 2'b11, 2'b10, 1'b0);
        cyc(1'b1, 5'd7, 5'd7, 64'h7777, 64'h8888, 2'b01, 2'b01, 1'b0);
        drain();

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            wi = i[1:0];
            cyc(1'b1, 5'(i + 9), 5'(i + 1), 64'hA000 + 64'(i), 64'hB000 + 64'(i), wi, wi, 1'b0);
            chk("stream_valid", out_valid, 1);
            chk("stream_occ_le1", (occ <= 2'd1), 1);
        end
        drain();

        // Backpressure: three offered, two held
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 5'(i + 20), 5'(i + 12), 64'hC000 + 64'(i), 64'hD000 + 64'(i), 2'b11, 2'b11, 1'b0);
        end
        chk("bp_occ", occ, 2);
        chk("bp_ready", in_ready, 0);
        chk("bp_held", exp_q.size(), 2);
        drain();

        // Flush with occ=1 plus same-cycle accept
        out_ready = 1'b0;
        cyc(1'b1, 5'd1, 5'd2, 64'hE1, 64'hE2, 2'b11, 2'b11, 1'b0);
        cyc(1'b1, 5'd3, 5'd4, 64'hE3, 64'hE4, 2'b11, 2'b11, 1'b1);
        chk("fl1_valid", out_valid, 0);
        chk("fl1_occ", occ, 0);
        chk("fl1_ready", in_ready, 1);

        // Flush with occ=2 while upstream still offers
        cyc(1'b1, 5'd5, 5'd6, 64'hF1, 64'hF2, 2'b11, 2'b11, 1'b0);
        cyc(1'b1, 5'd7, 5'd8, 64'hF3, 64'hF4, 2'b11, 2'b11, 1'b0);
        chk("fl2_pre_occ", occ, 2);
        cyc(1'b1, 5'd9, 5'd10, 64'hF5, 64'hF6, 2'b11, 2'b11, 1'b1);
        chk("fl2_valid", out_valid, 0);
        chk("fl2_occ", occ, 0);
        chk("fl2_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        cyc(1'b1, 5'd11, 5'd12, 64'h99, 64'h98, 2'b10, 2'b10, 1'b0);
        drain();

        // Asynchronous reset mid-stream with occ=2
        out_ready = 1'b0;
        cyc(1'b1, 5'd13, 5'd14, 64'h11, 64'h12, 2'b11, 2'b11, 1'b0);
        cyc(1'b1, 5'd15, 5'd16, 64'h13, 64'h14, 2'b11, 2'b11, 1'b0);
        chk("ar_pre_occ", occ, 2);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ready", in_ready, 1);
        chk("ar_addr", addr_o, 0);
        chk("ar_data", data_o, 0);
        chk("ar_wen", wen_o, 0);
        chk("ar_occ", occ, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        cyc(1'b1, 5'd17, 5'd18, 64'h21, 64'h22, 2'b01, 2'b01, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
